// File: rtl/hd_pkt_decoder_pkg.sv
// Shared types and helpers for the SECDED packet decoder (package hd_pkg).
// Optional error counters on the top are enabled with HD_ERR_CNT_EN.
package hd_pkg;

    // Packet FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BODY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } hd_state_t;

    // Per-codeword decode outcome.
    typedef enum logic [1:0] {
        CLEAN  = 2'd0,
        CORR   = 2'd1,
        UNCORR = 2'd2
    } hd_stat_t;

    // Debug view: FSM state plus the decoder's view of the current input word.
    // Syndrome is zero-extended to 6 bits, enough for a 64-bit codeword.
    typedef struct packed {
        hd_state_t state;
        hd_stat_t  stat;
        logic [5:0] syndrome;
    } hd_dbg_t;

    // Number of Hamming parity bits (excluding the overall parity at bit 0).
    function automatic int hd_par_bits(input int width);
        return $clog2(width);
    endfunction

    // Number of data bits carried by one codeword.
    function automatic int hd_data_bits(input int width);
        return width - hd_par_bits(width) - 1;
    endfunction

    // Codeword position of data bit k: data fills the non-power-of-two
    // positions above 0 in ascending order.
    function automatic int hd_data_pos(input int width, input int k);
        int n;
        n = 0;
        for (int i = 1; i < width; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (n == k) return i;
                n++;
            end
        end
        return 0;
    endfunction

endpackage

// File: rtl/hd_pkt_decoder_if.sv
// Stream bundle between a packet source/sink and hd_pkt_decoder.
//
// Handshake: a beat transfers on a rising clk edge where its valid and the
// matching ready are both high (wr_vld & in_rdy on the input side,
// out_vld & out_rdy on the output side). A source holds valid and payload
// stable until the transfer; ready may change freely and never waits on valid.
interface hd_pkt_decoder_if
    import hd_pkg::*;
#(
    parameter int CODE_WIDTH   = 16,
    parameter int PRIORITY_BIT = 3,
    parameter int PORT_BIT     = 4
);
    localparam int DW = hd_data_bits(CODE_WIDTH);

    logic                    wr_vld;
    logic                    wr_sop;
    logic                    wr_eop;
    logic [CODE_WIDTH-1:0]   wr_data;
    logic                    in_rdy;

    logic                    out_vld;
    logic                    out_rdy;
    logic                    out_sop;
    logic                    out_eop;
    logic [DW-1:0]           out_data;
    logic [PRIORITY_BIT-1:0] out_prior;
    logic [PORT_BIT-1:0]     out_port;

    logic                    pkt_done;
    logic                    pkt_drop;
    logic                    pkt_corr;

    // Packet source and sink side (testbench or upstream/downstream logic).
    modport master (
        output wr_vld, wr_sop, wr_eop, wr_data, out_rdy,
        input  in_rdy, out_vld, out_sop, out_eop, out_data, out_prior, out_port,
               pkt_done, pkt_drop, pkt_corr
    );

    // Decoder side.
    modport slave (
        input  wr_vld, wr_sop, wr_eop, wr_data, out_rdy,
        output in_rdy, out_vld, out_sop, out_eop, out_data, out_prior, out_port,
               pkt_done, pkt_drop, pkt_corr
    );
endinterface

// File: rtl/hd_secded_dec.sv
// Combinational SECDED Hamming decoder: corrects one flipped bit anywhere in
// the codeword (including the overall parity at bit 0) and flags two flips.
module hd_secded_dec
    import hd_pkg::*;
#(
    parameter  int CODE_WIDTH = 16,
    localparam int P          = hd_par_bits(CODE_WIDTH),
    localparam int DW         = hd_data_bits(CODE_WIDTH)
) (
    input  logic [CODE_WIDTH-1:0] code,
    output logic [DW-1:0]         data,
    output hd_stat_t              status,
    output logic [P-1:0]          syndrome
);
    logic [P-1:0]          syn;
    logic                  parity;
    logic [CODE_WIDTH-1:0] fixed;

    // Syndrome is the XOR of the indices of all set bits; odd overall parity
    // means exactly one flip, located at the syndrome (0 = parity bit itself).
    always_comb begin
        syn = '0;
        for (int i = 0; i < CODE_WIDTH; i++) begin
            if (code[i]) syn = syn ^ P'(i);
        end
        parity = ^code;
        fixed  = code;
        if (parity) fixed[syn] = ~code[syn];
        if (parity)          status = CORR;
        else if (syn != '0)  status = UNCORR;
        else                 status = CLEAN;
        syndrome = syn;
    end

    for (genvar k = 0; k < DW; k++) begin : g_data
        localparam int POS = hd_data_pos(CODE_WIDTH, k);
        assign data[k] = fixed[POS];
    end
endmodule

// File: rtl/hd_pkt_decoder.sv
// SECDED packet decoder: decodes every incoming codeword, buffers the
// corrected payload of one packet and replays it with header fields attached.
// Packets with an uncorrectable word or more than MAX_WORDS payload words are
// dropped whole. Define HD_ERR_CNT_EN to add saturating error counters.
module hd_pkt_decoder
    import hd_pkg::*;
#(
    parameter int CODE_WIDTH   = 16,
    parameter int PRIORITY_BIT = 3,
    parameter int PORT_BIT     = 4,
    parameter int MAX_WORDS    = 64
) (
    input  logic              clk,
    input  logic              rst,
    hd_pkt_decoder_if.slave   bus,
    output hd_dbg_t           dbg
`ifdef HD_ERR_CNT_EN
    ,
    output logic [15:0]       cnt_corr,
    output logic [15:0]       cnt_uncorr,
    output logic [15:0]       cnt_drop
`endif
);
    localparam int P  = hd_par_bits(CODE_WIDTH);
    localparam int DW = hd_data_bits(CODE_WIDTH);
    localparam int AW = $clog2(MAX_WORDS + 1);
    localparam int IW = $clog2(MAX_WORDS);
    localparam logic [AW-1:0] CNT_MAX = AW'(MAX_WORDS);
    localparam logic [AW-1:0] CNT_ONE = AW'(1);

    hd_state_t               state, state_nxt;
    logic [AW-1:0]           cnt, rd;
    logic                    drop_flag, corr_flag;
    logic [PRIORITY_BIT-1:0] prior;
    logic [PORT_BIT-1:0]     port;
    logic [DW-1:0]           buffer [MAX_WORDS];

    logic [DW-1:0]           dec_data;
    hd_stat_t                dec_stat;
    logic [P-1:0]            dec_syn;

    logic take, last_rd, in_rdy, out_vld, done_pulse, abort, wr_buf;

    hd_secded_dec #(.CODE_WIDTH(CODE_WIDTH)) u_dec (
        .code     (bus.wr_data),
        .data     (dec_data),
        .status   (dec_stat),
        .syndrome (dec_syn)
    );

    assign take    = bus.wr_vld && (state == IDLE || state == BODY);
    assign last_rd = (rd == cnt - CNT_ONE);
    assign wr_buf  = take && (state == BODY) && !bus.wr_sop && (cnt != CNT_MAX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        state_nxt  = state;
        in_rdy     = 1'b0;
        out_vld    = 1'b0;
        done_pulse = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (bus.wr_vld && bus.wr_sop)
                    state_nxt = bus.wr_eop ? DONE : BODY;
            end
            BODY: begin
                in_rdy = 1'b1;
                if (bus.wr_vld && bus.wr_sop) begin
                    // New header mid-packet: report the old one as dropped now.
                    abort     = 1'b1;
                    state_nxt = bus.wr_eop ? DONE : BODY;
                end else if (bus.wr_vld && bus.wr_eop) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_pulse = 1'b1;
                state_nxt  = (drop_flag || cnt == '0) ? IDLE : DRAIN;
            end
            DRAIN: begin
                out_vld = 1'b1;
                if (bus.out_rdy && last_rd) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Header, counters and per-packet flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            rd        <= '0;
            drop_flag <= 1'b0;
            corr_flag <= 1'b0;
            prior     <= '0;
            port      <= '0;
        end else begin
            if (take && bus.wr_sop) begin
                port      <= dec_data[PORT_BIT-1:0];
                prior     <= dec_data[PORT_BIT+PRIORITY_BIT-1:PORT_BIT];
                cnt       <= '0;
                drop_flag <= (dec_stat == UNCORR);
                corr_flag <= (dec_stat == CORR);
            end else if (take && state == BODY) begin
                if (dec_stat == UNCORR) drop_flag <= 1'b1;
                if (dec_stat == CORR)   corr_flag <= 1'b1;
                if (cnt == CNT_MAX)     drop_flag <= 1'b1;
                else                    cnt       <= cnt + CNT_ONE;
            end
            if (state == DONE)                  rd <= '0;
            else if (state == DRAIN && bus.out_rdy) rd <= rd + CNT_ONE;
        end
    end

    // Payload buffer; overflow words are never written.
    always_ff @(posedge clk) begin
        if (wr_buf) buffer[cnt[IW-1:0]] <= dec_data;
    end

`ifdef HD_ERR_CNT_EN
    // Saturating error statistics over words taken into packets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
            cnt_drop   <= '0;
        end else begin
            if (take && (bus.wr_sop || state == BODY)) begin
                if (dec_stat == CORR && cnt_corr != 16'hFFFF)
                    cnt_corr <= cnt_corr + 16'd1;
                if (dec_stat == UNCORR && cnt_uncorr != 16'hFFFF)
                    cnt_uncorr <= cnt_uncorr + 16'd1;
            end
            if (((done_pulse && drop_flag) || abort) && cnt_drop != 16'hFFFF)
                cnt_drop <= cnt_drop + 16'd1;
        end
    end
`endif

    assign bus.in_rdy    = in_rdy;
    assign bus.out_vld   = out_vld;
    assign bus.out_sop   = out_vld && (rd == '0);
    assign bus.out_eop   = out_vld && last_rd;
    assign bus.out_data  = out_vld ? buffer[rd[IW-1:0]] : '0;
    assign bus.out_prior = prior;
    assign bus.out_port  = port;
    assign bus.pkt_done  = done_pulse || abort;
    assign bus.pkt_drop  = (done_pulse && drop_flag) || abort;
    assign bus.pkt_corr  = (done_pulse || abort) && corr_flag;

    assign dbg = '{state: state, stat: dec_stat, syndrome: 6'(dec_syn)};
endmodule
